// File: rtl/sram_wr_ctrl_pkg.sv
// Shared types and default geometry for the SRAM write controller.
package sram_wr_ctrl_pkg;

  localparam int DEF_DISP_W     = 320;
  localparam int DEF_DISP_H     = 240;
  localparam int DEF_ADDR_W     = 17;
  localparam int DEF_FIFO_DEPTH = 4;

  // state   | meaning
  // IDLE    | accept pixels, drain write buffer to SRAM
  // CLEAR   | sweep every frame address with zero data
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Saturate a window coordinate to the last valid pixel index.
  function automatic logic [15:0] clamp_coord(input logic [15:0] v,
                                              input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sram_wr_ctrl_fifo.sv
// Small synchronous FIFO with flush and an unregistered (fall-through) read port.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the same cycle pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since empty gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sram_wr_ctrl.sv
// Frame-buffer SRAM write controller: windowed pixel writes through a small
// buffer, plus a full-frame zero clear that owns the SRAM port while active.
module sram_wr_ctrl
  import sram_wr_ctrl_pkg::*;
#(
  parameter int DISP_W     = DEF_DISP_W,
  parameter int DISP_H     = DEF_DISP_H,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pixel_data,
  input  logic [31:0]       i_col_addr,
  input  logic [31:0]       i_row_addr,
  input  logic              i_clr_req,
  input  logic              i_write_req,
  input  logic              i_waddr_set_req,
  input  logic              i_sram_busy,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_clearing,
  output logic              o_overflow
);

  localparam int                FW        = ADDR_W + 16;
  localparam logic [15:0]       X_MAX     = 16'(DISP_W - 1);
  localparam logic [15:0]       Y_MAX     = 16'(DISP_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(DISP_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DISP_W * DISP_H - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Window bounds, cursor, running row base and the window's first row base.
  logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] rb_q, rb_d, rb0_q, rb0_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;

  // Clamped window decoded straight from the request buses.
  logic [15:0]       ld_xs, ld_xe, ld_ys, ld_ye, xe_c, ye_c;
  logic [ADDR_W-1:0] ld_rb;

  // Window and cursor as seen by a write in this cycle (new window if loading).
  logic [15:0]       cur_xs, cur_xe, cur_ys, cur_ye, cur_x, cur_y;
  logic [ADDR_W-1:0] cur_rb, cur_rb0;
  logic              pop_ok;

  assign o_sram_we    = we_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_clearing   = (state_q == ST_CLEAR);
  assign o_overflow   = ovf_q;

  // Clamp the requested window; the only multiply lives here, on window load.
  always_comb begin
    ld_xs = clamp_coord(i_col_addr[31:16], X_MAX);
    xe_c  = clamp_coord(i_col_addr[15:0],  X_MAX);
    ld_xe = (ld_xs > xe_c) ? ld_xs : xe_c;
    ld_ys = clamp_coord(i_row_addr[31:16], Y_MAX);
    ye_c  = clamp_coord(i_row_addr[15:0],  Y_MAX);
    ld_ye = (ld_ys > ye_c) ? ld_ys : ye_c;
    ld_rb = ADDR_W'(32'(ld_ys) * 32'(DISP_W));
  end

  // Select the window a same-cycle write should use.
  always_comb begin
    cur_xs  = i_waddr_set_req ? ld_xs : xs_q;
    cur_xe  = i_waddr_set_req ? ld_xe : xe_q;
    cur_ys  = i_waddr_set_req ? ld_ys : ys_q;
    cur_ye  = i_waddr_set_req ? ld_ye : ye_q;
    cur_x   = i_waddr_set_req ? ld_xs : x_q;
    cur_y   = i_waddr_set_req ? ld_ys : y_q;
    cur_rb  = i_waddr_set_req ? ld_rb : rb_q;
    cur_rb0 = i_waddr_set_req ? ld_rb : rb0_q;
  end

  assign pop_ok = (state_q == ST_IDLE) && !fifo_empty && !i_sram_busy;

  // Next-state, cursor advance, buffer control and SRAM strobe generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    x_d        = x_q;
    y_d        = y_q;
    rb_d       = rb_q;
    rb0_d      = rb0_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    fifo_wdata = {cur_rb + ADDR_W'(cur_x), i_pixel_data};

    if (i_waddr_set_req) begin
      xs_d  = ld_xs;
      xe_d  = ld_xe;
      ys_d  = ld_ys;
      ye_d  = ld_ye;
      x_d   = ld_xs;
      y_d   = ld_ys;
      rb_d  = ld_rb;
      rb0_d = ld_rb;
    end

    case (state_q)
      ST_IDLE: begin
        if (pop_ok) begin
          fifo_pop = 1'b1;
          we_d     = 1'b1;
          addr_d   = fifo_rdata[FW-1:16];
          wdata_d  = fifo_rdata[15:0];
        end
      end
      ST_CLEAR: begin
        if (!i_sram_busy) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = 16'h0000;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_write_req) begin
      if ((state_q == ST_IDLE) && !i_clr_req && (!fifo_full || pop_ok)) begin
        fifo_push = 1'b1;
        if (cur_x != cur_xe) begin
          x_d = cur_x + 16'd1;
        end else begin
          x_d = cur_xs;
          if (cur_y != cur_ye) begin
            y_d  = cur_y + 16'd1;
            rb_d = cur_rb + ROW_STEP;
          end else begin
            y_d  = cur_ys;
            rb_d = cur_rb0;
          end
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    // A clear request overrides any pop, push or window load in the same cycle.
    if (i_clr_req) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      we_d       = 1'b0;
      state_d    = ST_CLEAR;
      cnt_d      = '0;
      xs_d       = 16'd0;
      xe_d       = X_MAX;
      ys_d       = 16'd0;
      ye_d       = Y_MAX;
      x_d        = 16'd0;
      y_d        = 16'd0;
      rb_d       = '0;
      rb0_d      = '0;
    end
  end

  // State and clear-address counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Window, cursor and registered SRAM outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xs_q    <= 16'd0;
      xe_q    <= X_MAX;
      ys_q    <= 16'd0;
      ye_q    <= Y_MAX;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      rb_q    <= '0;
      rb0_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rb_q    <= rb_d;
      rb0_q   <= rb0_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Bench for sram_wr_ctrl: table of windowed writes with constant expected
// addresses, scoreboard matched against SRAM strobes, plus clear, overflow
// and reset sequences.
module tb_sram_wr_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_pixel_data;
  logic [31:0] i_col_addr;
  logic [31:0] i_row_addr;
  logic        i_clr_req;
  logic        i_write_req;
  logic        i_waddr_set_req;
  logic        i_sram_busy;
  logic        o_sram_we;
  logic [16:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic        o_clearing;
  logic        o_overflow;

  sram_wr_ctrl #(
    .DISP_W     (320),
    .DISP_H     (240),
    .ADDR_W     (17),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pixel_data    (i_pixel_data),
    .i_col_addr      (i_col_addr),
    .i_row_addr      (i_row_addr),
    .i_clr_req       (i_clr_req),
    .i_write_req     (i_write_req),
    .i_waddr_set_req (i_waddr_set_req),
    .i_sram_busy     (i_sram_busy),
    .o_sram_we       (o_sram_we),
    .o_sram_addr     (o_sram_addr),
    .o_sram_wdata    (o_sram_wdata),
    .o_clearing      (o_clearing),
    .o_overflow      (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        set;
    logic [31:0] col;
    logic [31:0] row;
    logic [16:0] addr;
  } vec_t;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
    int          cyc;
  } sb_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];
  sb_t  sb [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 0;   // 0: scoreboard, 1: clear sweep check, 2: ignore strobes
  int clr_exp, clr_err, clr_cycles;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_clearing) clr_cycles++;
      if (o_sram_we) begin
        if (mode == 0) begin
          if (sb.size() == 0) begin
            chk("unexpected_we", 32'(o_sram_addr), 32'hFFFF_FFFF);
          end else begin
            sb_t e;
            e = sb.pop_front();
            chk("we_addr", 32'(o_sram_addr), 32'(e.addr));
            chk("we_data", 32'(o_sram_wdata), 32'(e.data));
            if (e.cyc >= 0) chk("we_latency", cyc, e.cyc);
          end
        end else if (mode == 1) begin
          if ((32'(o_sram_addr) != clr_exp) || (o_sram_wdata != 16'h0)) clr_err++;
          clr_exp++;
        end
      end
    end
  end

  task automatic write_px(input logic [15:0] d, input logic [16:0] a, input int lat_chk);
    i_write_req  = 1'b1;
    i_pixel_data = d;
    sb.push_back('{a, d, lat_chk ? cyc + 2 : -1});
    @(negedge i_clk);
    i_write_req  = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge i_clk);
    @(negedge i_clk);
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, {16'd10,  16'd12},  {16'd5,   16'd6},   17'd1610};
    vecs[1]  = '{1'b0, 32'd0,              32'd0,              17'd1611};
    vecs[2]  = '{1'b0, 32'd0,              32'd0,              17'd1612};
    vecs[3]  = '{1'b0, 32'd0,              32'd0,              17'd1930};
    vecs[4]  = '{1'b0, 32'd0,              32'd0,              17'd1931};
    vecs[5]  = '{1'b0, 32'd0,              32'd0,              17'd1932};
    vecs[6]  = '{1'b0, 32'd0,              32'd0,              17'd1610};
    vecs[7]  = '{1'b1, {16'd2,   16'd100}, {16'd1,   16'd10},  17'd322};
    vecs[8]  = '{1'b0, 32'd0,              32'd0,              17'd323};
    vecs[9]  = '{1'b1, {16'd400, 16'd500}, {16'd3,   16'd2},   17'd1279};
    vecs[10] = '{1'b0, 32'd0,              32'd0,              17'd1279};
    vecs[11] = '{1'b1, {16'd319, 16'd319}, {16'd239, 16'd239}, 17'd76799};
    vecs[12] = '{1'b0, 32'd0,              32'd0,              17'd76799};
    vecs[13] = '{1'b1, {16'd0,   16'd1},   {16'd0,   16'd0},   17'd0};
    vecs[14] = '{1'b0, 32'd0,              32'd0,              17'd1};
    vecs[15] = '{1'b0, 32'd0,              32'd0,              17'd0};
    vecs[16] = '{1'b1, {16'd5,   16'd3},   {16'd250, 16'd0},   17'd76485};

    i_rst_n = 1'b0;
    i_pixel_data = '0; i_col_addr = '0; i_row_addr = '0;
    i_clr_req = 1'b0; i_write_req = 1'b0; i_waddr_set_req = 1'b0; i_sram_busy = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_we",       32'(o_sram_we),    0);
    chk("rst_addr",     32'(o_sram_addr),  0);
    chk("rst_wdata",    32'(o_sram_wdata), 0);
    chk("rst_clearing", 32'(o_clearing),   0);
    chk("rst_overflow", 32'(o_overflow),   0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Table: back-to-back writes, some with a same-cycle window load.
    for (int i = 0; i < NVEC; i++) begin
      i_waddr_set_req = vecs[i].set;
      i_col_addr      = vecs[i].col;
      i_row_addr      = vecs[i].row;
      i_write_req     = 1'b1;
      i_pixel_data    = 16'hA000 + 16'(i);
      sb.push_back('{vecs[i].addr, i_pixel_data, cyc + 2});
      @(negedge i_clk);
    end
    i_write_req = 1'b0; i_waddr_set_req = 1'b0;
    drain("table_drain");
    chk("no_overflow_yet", 32'(o_overflow), 0);

    // Overflow: SRAM held busy, five writes into a four-entry buffer.
    i_waddr_set_req = 1'b1; i_col_addr = {16'd0, 16'd319}; i_row_addr = {16'd0, 16'd239};
    @(negedge i_clk);
    i_waddr_set_req = 1'b0;
    i_sram_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_write_req  = 1'b1;
      i_pixel_data = 16'hB000 + 16'(k);
      if (k < 4) sb.push_back('{17'(k), i_pixel_data, -1});
      @(negedge i_clk);
    end
    i_write_req = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("ovf_set",   32'(o_overflow), 1);
    chk("busy_hold", sb.size(), 4);
    i_sram_busy = 1'b0;
    drain("ovf_drain");
    write_px(16'hB0FF, 17'd4, 1);
    drain("ovf_cursor_drain");

    // Full-frame clear with the SRAM always free; a write mid-clear is dropped.
    mode = 1; clr_exp = 0; clr_err = 0; clr_cycles = 0;
    i_clr_req = 1'b1;
    @(negedge i_clk);
    i_clr_req = 1'b0;
    chk("clearing_asserted", 32'(o_clearing), 1);
    repeat (100) @(negedge i_clk);
    i_write_req = 1'b1; i_pixel_data = 16'hDEAD;
    @(negedge i_clk);
    i_write_req = 1'b0;
    for (int k = 0; k < 80000 && o_clearing; k++) @(negedge i_clk);
    chk("clear_done", 32'(o_clearing), 0);
    repeat (3) @(negedge i_clk);
    chk("clear_writes",   clr_exp,    76800);
    chk("clear_cycles",   clr_cycles, 76800);
    chk("clear_errors",   clr_err,    0);
    chk("ovf_sticky",     32'(o_overflow), 1);
    mode = 0;
    write_px(16'hC001, 17'd0, 1);
    write_px(16'hC002, 17'd1, 1);
    drain("post_clear_drain");

    // Reset mid-clear with a toggling busy.
    mode = 2;
    i_clr_req = 1'b1;
    @(negedge i_clk);
    i_clr_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      i_sram_busy = 1'($urandom_range(0, 1));
      @(negedge i_clk);
    end
    #3 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_we",       32'(o_sram_we),    0);
    chk("mid_rst_addr",     32'(o_sram_addr),  0);
    chk("mid_rst_wdata",    32'(o_sram_wdata), 0);
    chk("mid_rst_clearing", 32'(o_clearing),   0);
    chk("mid_rst_overflow", 32'(o_overflow),   0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_sram_busy = 1'b0;
    @(negedge i_clk);
    mode = 0;
    write_px(16'hE123, 17'd0, 1);
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
